add_sched: RTL and testbench
============================

ADD_SCHED -- requirements
Module: add_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the adder sequence; fixed at 4 in this release.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester request; bit i is held high until gnt[i] is seen.
REQ-005 a_bus  input  24  four 6-bit a operands; requester i drives bits [6i+5:6i].
REQ-006 b_bus  input  24  four 6-bit b operands, packed as a_bus.
REQ-007 gnt  output  4  registered one-hot grant, high for exactly one cycle.
REQ-008 busy  output  1  high while state is not IDLE.
REQ-009 done  output  1  registered one-cycle pulse; result and done_id valid while high.
REQ-010 done_id  output  2  index of the requester whose result is presented.
REQ-011 result  output  6  x+y, where x=a+b and y=x+3, all arithmetic modulo 64.

Function
REQ-012 States SHALL be IDLE, ADD1, ADD2, ADD3, one per clock.
REQ-013 IDLE, any req bit set at edge E0: pick winner w, latch a_w/b_w into operand registers, set gnt[w]=1 and cur_id=w, go to ADD1.
REQ-014 IDLE, req==0: stay in IDLE; gnt=0.
REQ-015 ADD1: x<=opa+opb (6-bit, carry discarded); go to ADD2.
REQ-016 ADD2: y<=x+3 (6-bit wrap); go to ADD3.
REQ-017 ADD3: result<=x+y (6-bit wrap), done<=1, done_id<=cur_id; go to IDLE.
REQ-018 Latency: done SHALL be high in the cycle after E0+3, i.e. three cycles after gnt.
REQ-019 result and done_id SHALL hold their last values until the next ADD3.
REQ-020 done SHALL be 0 in every cycle except the one following ADD3.
REQ-021 The IDLE cycle in which done is high SHALL arbitrate normally, giving a sustained throughput of one operation per 4 cycles.
REQ-022 req changes during ADD1–ADD3 SHALL be ignored; the operands latched at E0 are used.
REQ-023 A req bit still high in IDLE after its gnt SHALL be treated as a new request.
REQ-024 Default arbitration is round-robin: search starts at (last_gnt+1) mod 4; last_gnt updates on every grant.

Reset
REQ-025 While reset_n=0, state=IDLE, and gnt, done, done_id, result, busy, x, y and the operand registers are all 0.
REQ-026 While reset_n=0, last_gnt=3, so req[0] has first priority after reset.
REQ-027 Reset asserted mid-operation SHALL abort the operation: no done is issued and the pending request is lost.

Configuration
REQ-028 Macro ADD_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins; last_gnt SHALL NOT be implemented.
REQ-029 ADD_SCHED_FIXED_PRIO_EN undefined: round-robin per REQ-024.

Structure
REQ-030 Package add_sched_pkg SHALL hold the state enum (IDLE..ADD3), the operand width constant (6), the N_REQ constant (4) and the constant 3 added in ADD2.
REQ-031 Sub-module add_sched_dp SHALL hold the x/y/result registers and adders; add_sched SHALL hold the FSM and the arbiter.

Verification
REQ-032 Single request, rr mode: req=0001, a0=5, b0=7 -> gnt=0001 one cycle; done 3 cycles later with result=27, done_id=0.
REQ-033 Wrap-around: a=63, b=63 -> x=62, y=1, result=63.
REQ-034 Round-robin: req=1111 held, each bit dropped after its gnt and then reasserted -> grant order 0,1,2,3,0; done pulses spaced 4 cycles apart.
REQ-035 Fixed-priority build: req=0110 held -> gnt to requester 1 each time, requester 2 starved while req[1] stays high.
REQ-036 Reset mid-operation: reset_n low in ADD2 -> no done pulse, all outputs 0; after release, req=0100 -> gnt=0100 in rr mode.
REQ-037 Operand stability: change a_bus during ADD1–ADD3 -> result still matches the operands latched at E0.

Source files
------------

// File: rtl/add_sched_pkg.sv
// ============================================================================
//  Module  : add_sched_pkg
//  Purpose : Shared types and constants for the add_sched operation scheduler
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package add_sched_pkg;

   // Operation sequencer states, one clock each
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD1 = 2'd1,
      ADD2 = 2'd2,
      ADD3 = 2'd3
   } state_e;

   localparam int            OP_W    = 6;               // operand / result width
   localparam int            NUM_REQ = 4;               // requesters sharing the adder
   localparam int            ID_W    = 2;               // requester index width
   localparam logic [OP_W-1:0] ADD2_K = OP_W'(3);       // constant added in ADD2

endpackage

`default_nettype wire

// File: rtl/add_sched_dp.sv
// ============================================================================
//  Module  : add_sched_dp
//  Purpose : x / y / result registers and the three modulo-64 adders
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sched_dp
   import add_sched_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            add1_en_i,
   input  logic            add2_en_i,
   input  logic            add3_en_i,
   input  logic [OP_W-1:0] opa_i,
   input  logic [OP_W-1:0] opb_i,
   output logic [OP_W-1:0] result_o
);

   logic [OP_W-1:0] x_q, y_q, result_q;
   logic [OP_W-1:0] x_d, y_d, result_d;

   // Adders: carries drop out naturally at the 6-bit width
   assign x_d      = opa_i + opb_i;
   assign y_d      = x_q + ADD2_K;
   assign result_d = x_q + y_q;

   // Each stage register loads only in its own FSM state, otherwise holds
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q      <= '0;
         y_q      <= '0;
         result_q <= '0;
      end else begin
         if (add1_en_i) x_q      <= x_d;
         if (add2_en_i) y_q      <= y_d;
         if (add3_en_i) result_q <= result_d;
      end
   end

   assign result_o = result_q;

endmodule

`default_nettype wire

// File: rtl/add_sched.sv
// ============================================================================
//  Module  : add_sched
//  Purpose : Arbitrates N_REQ requesters onto a 3-step add sequence
//            (x=a+b, y=x+3, result=x+y, all modulo 64).
//            Build option ADD_SCHED_FIXED_PRIO_EN: fixed priority (lowest
//            index wins) instead of the default round-robin arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sched
   import add_sched_pkg::*;
#(
   parameter int N_REQ = NUM_REQ
)(
   input  logic                  CLK,
   input  logic                  reset_n,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*OP_W-1:0] a_bus,
   input  logic [N_REQ*OP_W-1:0] b_bus,
   output logic [N_REQ-1:0]      gnt,
   output logic                  busy,
   output logic                  done,
   output logic [ID_W-1:0]       done_id,
   output logic [OP_W-1:0]       result
);

   state_e            state_q;
   logic [N_REQ-1:0]  gnt_q;
   logic              done_q;
   logic [ID_W-1:0]   done_id_q;
   logic [ID_W-1:0]   cur_id_q;
   logic [OP_W-1:0]   opa_q, opb_q;

   logic              any_req;
   logic [ID_W-1:0]   win_id;
   logic [OP_W-1:0]   win_a, win_b;

`ifdef ADD_SCHED_FIXED_PRIO_EN
   // Fixed priority: scan from the top so the lowest set index wins
   always_comb begin
      any_req = 1'b0;
      win_id  = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            any_req = 1'b1;
            win_id  = ID_W'(i);
         end
      end
   end
`else
   logic [ID_W-1:0]   last_gnt_q;
   logic [ID_W-1:0]   scan_idx;

   // Round-robin: first set bit starting one past the last winner
   always_comb begin
      any_req  = 1'b0;
      win_id   = '0;
      scan_idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_idx = last_gnt_q + ID_W'(1) + ID_W'(i);
         if (!any_req && req[scan_idx]) begin
            any_req = 1'b1;
            win_id  = scan_idx;
         end
      end
   end

   // Pointer advances on every grant; reset value makes requester 0 first
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt_q <= ID_W'(N_REQ - 1);
      end else if (state_q == IDLE && any_req) begin
         last_gnt_q <= win_id;
      end
   end
`endif

   assign win_a = a_bus[win_id*OP_W +: OP_W];
   assign win_b = b_bus[win_id*OP_W +: OP_W];

   // Sequencer with registered grant / done outputs and operand capture
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         cur_id_q  <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
      end else begin
         gnt_q  <= '0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  opa_q    <= win_a;
                  opb_q    <= win_b;
                  gnt_q    <= N_REQ'(1) << win_id;
                  cur_id_q <= win_id;
                  state_q  <= ADD1;
               end
            end
            ADD1: state_q <= ADD2;
            ADD2: state_q <= ADD3;
            ADD3: begin
               done_q    <= 1'b1;
               done_id_q <= cur_id_q;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   add_sched_dp u_dp (
      .clk_i     (CLK),
      .rst_ni    (reset_n),
      .add1_en_i (state_q == ADD1),
      .add2_en_i (state_q == ADD2),
      .add3_en_i (state_q == ADD3),
      .opa_i     (opa_q),
      .opb_i     (opb_q),
      .result_o  (result)
   );

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign done_id = done_id_q;
   assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_add_sched.sv
// ============================================================================
//  Module  : tb_add_sched
//  Purpose : Directed, table-driven self-checking bench for add_sched
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_sched;

   logic        CLK;
   logic        reset_n;
   logic [3:0]  req;
   logic [23:0] a_bus;
   logic [23:0] b_bus;
   logic [3:0]  gnt;
   logic        busy;
   logic        done;
   logic [1:0]  done_id;
   logic [5:0]  result;

   int n_tests = 0;
   int n_fail  = 0;

   add_sched dut (
      .CLK     (CLK),
      .reset_n (reset_n),
      .req     (req),
      .a_bus   (a_bus),
      .b_bus   (b_bus),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .result  (result)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0] req;
      logic [5:0] a;
      logic [5:0] b;
      logic [1:0] id_rr;
      logic [1:0] id_fp;
      logic [5:0] res;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [1:0] exp_id(input vec_t v);
`ifdef ADD_SCHED_FIXED_PRIO_EN
      return v.id_fp;
`else
      return v.id_rr;
`endif
   endfunction

   // Lane i: a=i+1, b=2i  -> results 5, 11, 17, 23
   task automatic set_lanes();
      for (int k = 0; k < 4; k++) begin
         a_bus[k*6 +: 6] = 6'(k + 1);
         b_bus[k*6 +: 6] = 6'(2 * k);
      end
   endtask

   initial begin
      logic [1:0] w;
      logic [5:0] last_res;
      logic [1:0] order [5];
      logic [5:0] lane_res [4];

      //           req      a   b  rr fp  result = 2*((a+b)%64)+3 mod 64
      vecs[0] = '{4'b0001,  5,  7, 0, 0, 27};
      vecs[1] = '{4'b1111, 63, 63, 1, 0, 63};
      vecs[2] = '{4'b1111, 10, 21, 2, 0,  1};
      vecs[3] = '{4'b1001,  0,  0, 3, 0,  3};
      vecs[4] = '{4'b1111, 33, 40, 0, 0, 21};
      vecs[5] = '{4'b0110,  1,  2, 1, 1,  9};
      vecs[6] = '{4'b0110, 20, 25, 2, 1, 29};
      vecs[7] = '{4'b1100, 50, 13, 3, 2,  1};

      lane_res = '{6'd5, 6'd11, 6'd17, 6'd23};
`ifdef ADD_SCHED_FIXED_PRIO_EN
      order = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif

      reset_n = 1'b0;
      req     = '0;
      a_bus   = '0;
      b_bus   = '0;
      tick();
      tick();
      chk("rst_gnt",     gnt,     0);
      chk("rst_busy",    busy,    0);
      chk("rst_done",    done,    0);
      chk("rst_done_id", done_id, 0);
      chk("rst_result",  result,  0);
      reset_n = 1'b1;
      tick();
      chk("idle_gnt", gnt, 0);

      // ---------------- table-driven single operations -------------------
      for (int v = 0; v < 8; v++) begin
         w = exp_id(vecs[v]);
         for (int k = 0; k < 4; k++) begin
            a_bus[k*6 +: 6] = vecs[v].a + 6'(13 * (k + 1));
            b_bus[k*6 +: 6] = vecs[v].b ^ 6'(k + 1);
         end
         a_bus[w*6 +: 6] = vecs[v].a;
         b_bus[w*6 +: 6] = vecs[v].b;
         req = vecs[v].req;
         tick();                                   // E0 taken
         chk($sformatf("v%0d_gnt", v), gnt, 32'(4'b0001 << w));
         chk($sformatf("v%0d_busy", v), busy, 1);
         chk($sformatf("v%0d_done0", v), done, 0);
         req   = '0;
         a_bus = ~a_bus;                           // must not affect result
         b_bus = b_bus ^ 24'h5A5A5A;
         tick();
         chk($sformatf("v%0d_gnt1", v), gnt, 0);
         tick();
         chk($sformatf("v%0d_done2", v), done, 0);
         tick();                                   // ADD3 done
         chk($sformatf("v%0d_done", v), done, 1);
         chk($sformatf("v%0d_result", v), result, vecs[v].res);
         chk($sformatf("v%0d_id", v), done_id, w);
         chk($sformatf("v%0d_busy3", v), busy, 0);
         tick();
         chk($sformatf("v%0d_done_off", v), done, 0);
         chk($sformatf("v%0d_res_hold", v), result, vecs[v].res);
         chk($sformatf("v%0d_id_hold", v), done_id, w);
      end

      // ---------------- back-to-back throughput from reset ---------------
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      set_lanes();
      req = 4'b1111;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (t % 4 == 0)
            chk($sformatf("tp%0d_gnt", t), gnt, 32'(4'b0001 << order[t/4]));
         else
            chk($sformatf("tp%0d_gnt", t), gnt, 0);
         if (t % 4 == 3) begin
            chk($sformatf("tp%0d_done", t), done, 1);
            chk($sformatf("tp%0d_id", t), done_id, order[t/4]);
            chk($sformatf("tp%0d_res", t), result, lane_res[order[t/4]]);
         end else begin
            chk($sformatf("tp%0d_done", t), done, 0);
         end
         req = 4'b1111 & ~gnt;                     // drop granted bit one cycle
      end
      req = '0;
      tick();
      last_res = result;
      chk("tp_idle_done", done, 0);

      // ---------------- reset in the middle of an operation --------------
      req = 4'b0001;
      tick();
      chk("mr_gnt", gnt, 4'b0001);
      req = '0;
      tick();                                      // now in ADD2
      reset_n = 1'b0;
      #1;
      chk("mr_busy",   busy,    0);
      chk("mr_done",   done,    0);
      chk("mr_result", result,  0);
      chk("mr_id",     done_id, 0);
      chk("mr_gnt0",   gnt,     0);
      chk("mr_prev_nonzero", (last_res != 0), 1);
      tick();
      chk("mr_done_hold", done, 0);
      reset_n = 1'b1;
      tick();
      chk("mr_post_done", done, 0);
      tick();
      chk("mr_post_done2", done, 0);
      req = 4'b0100;
      tick();
      chk("mr_new_gnt", gnt, 4'b0100);
      req = '0;
      tick();
      tick();
      tick();
      chk("mr_new_done", done, 1);
      chk("mr_new_res",  result, 17);
      chk("mr_new_id",   done_id, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
